serial_adder_ctrl: RTL

//  Bit-serial N-bit adder controller. Accepts two WIDTH-bit operands on a start

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding for the bit-serial adder controller
package serial_adder_pkg;

    // Controller states; encoding 2'd3 is unreachable and treated as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
module half_adder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B;
    assign Carry = A & B;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 most recent sum bits, newest at the MSB; the final
    // bit is merged in combinationally when the result is committed.
    logic [WIDTH-2:0] s_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             ha0_sum;
    logic             ha0_carry;
    logic             ha1_sum;
    logic             ha1_carry;
    logic             bit_out;
    logic             cout;
    logic             last_bit;
    logic [WIDTH-1:0] s_next;

    // Full-adder cell built from two shared half adders.
    half_adder u_ha0 (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Sum  (ha0_sum),
        .Carry(ha0_carry)
    );

    half_adder u_ha1 (
        .A    (ha0_sum),
        .B    (c),
        .Sum  (ha1_sum),
        .Carry(ha1_carry)
    );

    assign bit_out  = ha1_sum;
    assign cout     = ha0_carry | ha1_carry;
    assign last_bit = (cnt == CNT_LAST);
    assign s_next   = {bit_out, s_sr};

    // Next-state and status decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = Start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                Busy      = 1'b1;
                state_nxt = last_bit ? S_DONE : S_RUN;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, serial shifting, carry/counter update and result commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_sr <= A;
                        b_sr <= B;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next[WIDTH-1:1];
                    c    <= cout;
                    if (last_bit) begin
                        Sum   <= s_next;
                        Carry <= cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
